// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared types and constants for the branch prediction unit:
//                branch op encoding, 2-bit counter values, and the FSM
//                state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Branch op encoding as carried in the EX stage. Code 7 behaves as NONE.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_BEQ  = 3'd1,
        OP_BNE  = 3'd2,
        OP_BLTZ = 3'd3,
        OP_BGTZ = 3'd4,
        OP_BLEZ = 3'd5,
        OP_BGEZ = 3'd6,
        OP_RSVD = 3'd7
    } br_op_t;

    // 2-bit saturating counter values; the MSB is the prediction.
    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    localparam logic [1:0] CTR_INIT_DEFAULT = CTR_WNT;

    // Table sweep after reset, then normal operation.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bpu_state_t;

endpackage : branch_pkg
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cond_eval
//  Description : Combinational evaluation of the six MIPS conditional
//                branches from raw register operands.
//  Ports       : op        - branch op code (branch_pkg::br_op_t encoding)
//                rs_val    - first operand
//                rt_val    - second operand (BEQ/BNE only)
//                is_branch - op is one of the six conditional branches
//                taken     - branch condition holds (0 when not a branch)
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              is_branch,
    output logic              taken
);

    logic w_neg;
    logic w_zero;
    logic w_eq;

    // Signed compare against zero reduces to sign bit and zero detect.
    assign w_neg  = rs_val[DATA_W-1];
    assign w_zero = (rs_val == '0);
    assign w_eq   = (rs_val == rt_val);

    always_comb begin
        is_branch = 1'b1;
        taken     = 1'b0;
        case (br_op_t'(op))
            OP_BEQ:  taken = w_eq;
            OP_BNE:  taken = !w_eq;
            OP_BLTZ: taken = w_neg;
            OP_BGTZ: taken = !w_neg && !w_zero;
            OP_BLEZ: taken = w_neg || w_zero;
            OP_BGEZ: taken = !w_neg;
            default: is_branch = 1'b0;
        endcase
    end

endmodule : branch_cond_eval
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_unit
//  Description : Direct-mapped table of 2-bit saturating counters indexed by
//                PC. IF reads a combinational prediction; EX resolves the
//                branch internally, updates the table and produces a
//                registered mispredict flag and saturating statistics.
//                After reset the table is swept to CTR_INIT.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                ready             - sweep done, lookups/updates active
//                if_pc/pred_taken  - fetch lookup
//                ex_*              - EX-stage branch to resolve
//                rs_val/rt_val     - register operands of the EX branch
//                res_valid/res_taken/mispredict - registered resolve result
//                branch_cnt/mispredict_cnt      - saturating statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         PC_W      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CTR_INIT  = CTR_INIT_DEFAULT,
    parameter int         CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    input  logic              ex_valid,
    input  logic [2:0]        ex_op,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              ex_pred_taken,
    output logic              res_valid,
    output logic              res_taken,
    output logic              mispredict,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int               IDX_W      = $clog2(BHT_DEPTH);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(BHT_DEPTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    bpu_state_t       r_state;
    bpu_state_t       w_state_nxt;
    logic             w_ready;
    logic [IDX_W-1:0] r_init_idx;
    logic [1:0]       r_bht [BHT_DEPTH];

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_is_branch;
    logic             w_taken;
    logic             w_resolve;
    logic             w_mispredict;
    logic [1:0]       w_ctr_cur;
    logic [1:0]       w_ctr_nxt;

    logic             r_res_valid;
    logic             r_res_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;

    // PCs are word aligned; only the index bits select an entry.
    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];

    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                                ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

    branch_cond_eval #(
        .DATA_W    (DATA_W)
    ) u_cond (
        .op        (ex_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .is_branch (w_is_branch),
        .taken     (w_taken)
    );

    // ------------------------------------------------------------------
    // Sweep / run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_idx == C_LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ready = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_idx <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_idx <= r_init_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Counter table. Not reset: the sweep defines every entry before use.
    // ------------------------------------------------------------------
    assign w_resolve    = ex_valid && w_ready && w_is_branch;
    assign w_mispredict = (w_taken != ex_pred_taken);
    assign w_ctr_cur    = r_bht[w_ex_idx];

    always_comb begin
        w_ctr_nxt = w_ctr_cur;
        if (w_taken) begin
            if (w_ctr_cur != CTR_ST) begin
                w_ctr_nxt = w_ctr_cur + 2'd1;
            end
        end else begin
            if (w_ctr_cur != CTR_SNT) begin
                w_ctr_nxt = w_ctr_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                r_bht[r_init_idx] <= CTR_INIT;
            end else if (w_resolve) begin
                r_bht[w_ex_idx] <= w_ctr_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Resolve pipeline register and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid      <= 1'b0;
            r_res_taken      <= 1'b0;
            r_mispredict     <= 1'b0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_res_valid  <= w_resolve;
            r_res_taken  <= w_resolve && w_taken;
            r_mispredict <= w_resolve && w_mispredict;
            if (w_resolve && (r_branch_cnt != C_CNT_MAX)) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_resolve && w_mispredict && (r_mispredict_cnt != C_CNT_MAX)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
            end
        end
    end

    assign ready          = w_ready;
    assign pred_taken     = w_ready && r_bht[w_if_idx][1];
    assign res_valid      = r_res_valid;
    assign res_taken      = r_res_taken;
    assign mispredict     = r_mispredict;
    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule : branch_predict_unit
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predict_unit
//  Description : Self-checking bench for branch_predict_unit. A behavioural
//                model tracks readiness, counter table and statistics and is
//                compared every cycle; directed literal checks pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    localparam int DEPTH = 64;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic [31:0]   if_pc;
    logic          pred_taken;
    logic          ex_valid;
    logic [2:0]    ex_op;
    logic [31:0]   ex_pc;
    logic [31:0]   rs_val;
    logic [31:0]   rt_val;
    logic          ex_pred_taken;
    logic          res_valid;
    logic          res_taken;
    logic          mispredict;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispredict_cnt;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .DATA_W         (32),
        .PC_W           (32),
        .BHT_DEPTH      (DEPTH),
        .CTR_INIT       (2'b01),
        .CNT_W          (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ready          (ready),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_op          (ex_op),
        .ex_pc          (ex_pc),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .ex_pred_taken  (ex_pred_taken),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .mispredict     (mispredict),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_edges;            // rising edges with rst low since last reset
    int m_tbl [DEPTH];
    bit m_rv, m_rt, m_mp;
    int m_bc, m_mc;
    bit m_rdy, m_tk;
    int m_ix;

    function automatic bit cond(input int op, input logic [31:0] rs, input logic [31:0] rt);
        case (op)
            1: return rs == rt;
            2: return rs != rt;
            3: return $signed(rs) <  0;
            4: return $signed(rs) >  0;
            5: return $signed(rs) <= 0;
            6: return $signed(rs) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_edges = 0;
            m_rv = 0; m_rt = 0; m_mp = 0;
            m_bc = 0; m_mc = 0;
        end else begin
            m_rdy = (m_edges >= DEPTH);
            m_rv = 0; m_rt = 0; m_mp = 0;
            if (m_rdy && ex_valid && ex_op >= 3'd1 && ex_op <= 3'd6) begin
                m_tk = cond(int'(ex_op), rs_val, rt_val);
                m_ix = idx_of(ex_pc);
                if (m_tk) m_tbl[m_ix] = (m_tbl[m_ix] < 3) ? m_tbl[m_ix] + 1 : 3;
                else      m_tbl[m_ix] = (m_tbl[m_ix] > 0) ? m_tbl[m_ix] - 1 : 0;
                m_rv = 1;
                m_rt = m_tk;
                m_mp = (m_tk != ex_pred_taken);
                if (m_bc < CMAX) m_bc++;
                if (m_mp && m_mc < CMAX) m_mc++;
            end
            if (m_edges < DEPTH) begin
                m_edges++;
                if (m_edges == DEPTH) begin
                    foreach (m_tbl[i]) m_tbl[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready", {31'd0, ready}, {31'd0, m_edges >= DEPTH});
            check("pred_taken", {31'd0, pred_taken},
                  {31'd0, (m_edges >= DEPTH) && (m_tbl[idx_of(if_pc)] >= 2)});
            check("res_valid", {31'd0, res_valid}, {31'd0, m_rv});
            check("res_taken", {31'd0, res_taken}, {31'd0, m_rt});
            check("mispredict", {31'd0, mispredict}, {31'd0, m_mp});
            check("branch_cnt", {28'd0, branch_cnt}, m_bc);
            check("mispredict_cnt", {28'd0, mispredict_cnt}, m_mc);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [2:0] op, input logic [31:0] pc,
                           input logic [31:0] rs, input logic [31:0] rt, input logic pt);
        ex_valid = 1'b1; ex_op = op; ex_pc = pc;
        rs_val = rs; rt_val = rt; ex_pred_taken = pt;
        tick();
        ex_valid = 1'b0;
    endtask

    logic [2:0]  s_op  [8] = '{3'd3, 3'd5, 3'd4, 3'd6, 3'd5, 3'd6, 3'd3, 3'd4};
    logic [31:0] s_rs  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'h0, 32'h0, 32'h0, 32'h0};
    logic        s_exp [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        rst = 1'b1; if_pc = 32'h0; ex_valid = 1'b0; ex_op = 3'd0; ex_pc = 32'h0;
        rs_val = 32'h0; rt_val = 32'h0; ex_pred_taken = 1'b0;
        tick();
        cmp_en = 1'b1;
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_branch_cnt", {28'd0, branch_cnt}, 32'd0);
        tick();
        rst = 1'b0;

        // Idle sweep: ready rises after exactly DEPTH edges.
        for (int i = 1; i <= DEPTH; i++) begin
            if_pc = 32'h100 + 32'(i * 4);
            tick();
            if (i == 10) check("init_pred", {31'd0, pred_taken}, 32'd0);
            if (i == DEPTH - 1) check("ready_before", {31'd0, ready}, 32'd0);
            if (i == DEPTH) check("ready_after", {31'd0, ready}, 32'd1);
        end
        check("idle_mispredict_cnt", {28'd0, mispredict_cnt}, 32'd0);

        // BEQ taken, predicted not taken.
        resolve(3'd1, 32'h100, 32'd5, 32'd5, 1'b0);
        check("beq_res_valid", {31'd0, res_valid}, 32'd1);
        check("beq_res_taken", {31'd0, res_taken}, 32'd1);
        check("beq_mispredict", {31'd0, mispredict}, 32'd1);
        check("beq_mispredict_cnt", {28'd0, mispredict_cnt}, 32'd1);
        tick();
        check("beq_pulse", {31'd0, res_valid}, 32'd0);
        resolve(3'd1, 32'h100, 32'd5, 32'd5, 1'b0);
        if_pc = 32'h100;
        #1;
        check("beq_pred_after", {31'd0, pred_taken}, 32'd1);

        // Signed zero-compare ops; rt_val must be ignored.
        for (int i = 0; i < 8; i++) begin
            resolve(s_op[i], 32'h40, s_rs[i], 32'h12345, 1'b0);
            check($sformatf("signed_op%0d_rs%0h", s_op[i], s_rs[i]),
                  {31'd0, res_taken}, {31'd0, s_exp[i]});
        end

        // Same-cycle lookup and update at index 3: no bypass.
        if_pc = 32'hC;
        ex_valid = 1'b1; ex_op = 3'd1; ex_pc = 32'hC;
        rs_val = 32'd1; rt_val = 32'd1; ex_pred_taken = 1'b0;
        #1;
        check("same_cycle_pred_pre", {31'd0, pred_taken}, 32'd0);
        tick();
        ex_valid = 1'b0;
        check("same_cycle_pred_post", {31'd0, pred_taken}, 32'd1);

        // Saturation at index 8.
        for (int i = 0; i < 5; i++) resolve(3'd1, 32'h20, 32'd7, 32'd7, 1'b1);
        if_pc = 32'h20;
        resolve(3'd2, 32'h20, 32'd7, 32'd7, 1'b1);
        check("sat_pred_after_one_nt", {31'd0, pred_taken}, 32'd1);
        resolve(3'd2, 32'h20, 32'd7, 32'd7, 1'b1);
        check("sat_pred_after_two_nt", {31'd0, pred_taken}, 32'd0);

        // 18 resolves so far; NONE and code 7 must not count.
        resolve(3'd0, 32'h24, 32'd0, 32'd0, 1'b0);
        resolve(3'd7, 32'h24, 32'd0, 32'd0, 1'b0);
        check("none_no_res", {31'd0, res_valid}, 32'd0);
        resolve(3'd2, 32'h24, 32'd1, 32'd2, 1'b1);
        resolve(3'd2, 32'h24, 32'd1, 32'd2, 1'b1);
        check("branch_cnt_sat", {28'd0, branch_cnt}, 32'd15);

        // Reset mid-sweep with ex_valid held high throughout INIT.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ex_valid = 1'b1; ex_op = 3'd1; ex_pc = 32'h8;
        rs_val = 32'd3; rt_val = 32'd3; ex_pred_taken = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("mid_sweep_ready", {31'd0, ready}, 32'd0);
        check("mid_sweep_branch_cnt", {28'd0, branch_cnt}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            if (i == DEPTH - 1) begin
                check("resweep_ready_before", {31'd0, ready}, 32'd0);
                check("resweep_no_res", {31'd0, res_valid}, 32'd0);
            end
            if (i == DEPTH) check("resweep_ready_after", {31'd0, ready}, 32'd1);
        end
        tick();
        ex_valid = 1'b0;
        check("first_run_res_valid", {31'd0, res_valid}, 32'd1);
        check("first_run_branch_cnt", {28'd0, branch_cnt}, 32'd1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_branch_predict_unit
`default_nettype wire
